rcv_bit_timer: RTL

Parametrised, single-clock bit-timing engine for the UART-style serial receiver. Once the receive controller enables it, the block generates one sample strobe per bit at a programmable point in each bit period. It counts those strobes up to a programmable packet length, then flags packet completion. All counting is in the `clk` domain and no strobe is ever used as a clock. The block sits between the start-bit detector/receive controller and the receive shift register.

---
 rtl/rcv_bit_timer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rcv_bit_timer.sv
// Bit-timing engine for the serial receiver: one sample strobe per bit at a
// programmable in-period offset, counted up to a programmable packet length.
module rcv_bit_timer #(
  parameter int CLK_CNT_BITS = 8,
  parameter int BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    enable_timer,
  input  logic [CLK_CNT_BITS-1:0] bit_period,
  input  logic [CLK_CNT_BITS-1:0] sample_point,
  input  logic [BIT_CNT_BITS-1:0] packet_bits,
  output logic                    shift_enable,
  output logic                    packet_done,
  output logic [BIT_CNT_BITS-1:0] bit_count,
  output logic                    timer_busy,
  output logic                    cfg_err
);

  typedef enum logic [1:0] {IDLE, TIMING, DONE} state_t;

  localparam logic [CLK_CNT_BITS-1:0] CLK_ZERO = '0;
  localparam logic [CLK_CNT_BITS-1:0] CLK_ONE  = CLK_CNT_BITS'(1);
  localparam logic [CLK_CNT_BITS-1:0] CLK_TWO  = CLK_CNT_BITS'(2);
  localparam logic [BIT_CNT_BITS-1:0] BIT_ZERO = '0;
  localparam logic [BIT_CNT_BITS-1:0] BIT_ONE  = BIT_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [CLK_CNT_BITS-1:0] clk_count_q, clk_count_d;
  logic [BIT_CNT_BITS-1:0] bit_count_q, bit_count_d;
  logic                    packet_done_q, packet_done_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [CLK_CNT_BITS-1:0] period_q, period_d;
  logic [CLK_CNT_BITS-1:0] sample_q, sample_d;
  logic [BIT_CNT_BITS-1:0] bits_q, bits_d;

  logic                    cfg_ok;
  logic                    strobe;
  logic [BIT_CNT_BITS-1:0] bit_count_inc;

  assign cfg_ok = (bit_period >= CLK_TWO) && (sample_point != CLK_ZERO) &&
                  (sample_point <= bit_period) && (packet_bits != BIT_ZERO);
  assign strobe        = (state_q == TIMING) && (clk_count_q == sample_q);
  assign bit_count_inc = bit_count_q + BIT_ONE;

  always_comb begin
    state_d       = state_q;
    clk_count_d   = clk_count_q;
    bit_count_d   = bit_count_q;
    packet_done_d = 1'b0;
    cfg_err_d     = cfg_err_q;
    period_d      = period_q;
    sample_d      = sample_q;
    bits_d        = bits_q;
    case (state_q)
      IDLE: begin
        clk_count_d = CLK_ZERO;
        bit_count_d = BIT_ZERO;
        cfg_err_d   = 1'b0;
        if (enable_timer) begin
          // Shadow copies make mid-packet input changes invisible.
          period_d = bit_period;
          sample_d = sample_point;
          bits_d   = packet_bits;
          if (cfg_ok) begin
            state_d     = TIMING;
            clk_count_d = CLK_ONE;
          end else begin
            state_d   = DONE;
            cfg_err_d = 1'b1;
          end
        end
      end
      TIMING: begin
        if (!enable_timer) begin
          state_d     = IDLE;
          clk_count_d = CLK_ZERO;
          bit_count_d = BIT_ZERO;
        end else begin
          clk_count_d = (clk_count_q == period_q) ? CLK_ONE : clk_count_q + CLK_ONE;
          if (strobe) begin
            bit_count_d = bit_count_inc;
            if (bit_count_inc == bits_q) begin
              state_d       = DONE;
              packet_done_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!enable_timer) begin
          state_d     = IDLE;
          clk_count_d = CLK_ZERO;
          bit_count_d = BIT_ZERO;
          cfg_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      clk_count_q   <= CLK_ZERO;
      bit_count_q   <= BIT_ZERO;
      packet_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      period_q      <= CLK_ZERO;
      sample_q      <= CLK_ZERO;
      bits_q        <= BIT_ZERO;
    end else begin
      state_q       <= state_d;
      clk_count_q   <= clk_count_d;
      bit_count_q   <= bit_count_d;
      packet_done_q <= packet_done_d;
      cfg_err_q     <= cfg_err_d;
      period_q      <= period_d;
      sample_q      <= sample_d;
      bits_q        <= bits_d;
    end
  end

  assign shift_enable = strobe;
  assign packet_done  = packet_done_q;
  assign bit_count    = bit_count_q;
  assign timer_busy   = (state_q == TIMING);
  assign cfg_err      = cfg_err_q;

endmodule
